avalon_mm_data_memory_slave: RTL and testbench

Avalon-MM slave (responder) that answers the processor's data-side Avalon-MM master: a word-addressed 32-bit data RAM with a programmable number of wait states signalled through `s_waitrequest`. It sits on the system interconnect as the processor's data memory and is the other end of the data-interface handshake. Read data is presented in the completion cycle and held afterwards, so masters that sample either during or one cycle after `waitrequest` falls both capture it.

---
 rtl/avalon_mm_data_memory_slave_pkg.sv | 17 +
 rtl/avalon_mm_data_memory_slave_data_ram_sp.sv | 24 ++
 rtl/avalon_mm_data_memory_slave.sv | 87 ++++++++
 tb/tb_avalon_mm_data_memory_slave.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_data_memory_slave_pkg.sv
// avalon_mm_data_memory_slave_pkg: FSM encodings, out-of-window read value and
// the command record latched at acceptance, shared with the master-side interface.
package avalon_mm_data_memory_slave_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_ACK  = 2'b10;

    localparam logic [31:0] OOR_READ_DATA = 32'h0;

    typedef struct packed {
        logic        write;
        logic        in_win;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/avalon_mm_data_memory_slave_data_ram_sp.sv
// data_ram_sp: single-port DEPTHx32 RAM, synchronous write and registered read
// with read enable, so the output holds between reads (block-RAM inferable).
module data_ram_sp #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/avalon_mm_data_memory_slave.sv
// avalon_mm_data_memory_slave: word-addressed 32-bit data RAM on Avalon-MM with
// WAIT_CYCLES programmable wait states and out-of-window error pulse.
module avalon_mm_data_memory_slave
    import avalon_mm_data_memory_slave_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_address,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic        access_error
);

    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    logic [1:0]        state, state_n;
    logic [3:0]        cnt;
    cmd_t              cmd;
    logic [ADDR_W-1:0] cmd_word, word, ram_addr;
    logic [31:0]       offset, ram_q;
    logic              req, accept, hit, rd_from_ram, ram_we, ram_re;

    assign req    = s_read | s_write;
    assign accept = state == ST_IDLE && req;
    assign offset = s_address - BASE_ADDR;
    assign word   = offset[ADDR_W+1:2];
    assign hit    = s_address >= BASE_ADDR && (offset >> 2) < DEPTH_W;

    always_comb begin
        state_n = state == ST_IDLE ? (req ? (WAIT_CYCLES == 0 ? ST_ACK : ST_BUSY) : ST_IDLE)
                : state == ST_BUSY ? (!req ? ST_IDLE : cnt == 4'd0 ? ST_ACK : ST_BUSY)
                : ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            cmd         <= '0;
            cmd_word    <= '0;
            rd_from_ram <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cmd         <= '{write: s_write & ~s_read, in_win: hit, wdata: s_writedata};
                cmd_word    <= word;
                cnt         <= CNT_INIT;
                if (s_read)
                    rd_from_ram <= hit;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // The RAM is read with the live address at acceptance and written with the latched one in ACK.
    assign ram_re   = accept && s_read && hit;
    assign ram_we   = state == ST_ACK && cmd.write && cmd.in_win;
    assign ram_addr = state == ST_IDLE ? word : cmd_word;

    data_ram_sp #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(cmd.wdata),
        .rdata(ram_q)
    );

    // rd_from_ram is cleared by reset, so the unreset RAM output never reaches the bus.
    assign s_readdata    = rd_from_ram ? ram_q : OOR_READ_DATA;
    assign s_waitrequest = state != ST_ACK;
    assign access_error  = state == ST_ACK && !cmd.in_win;

endmodule

// File: tb/tb_avalon_mm_data_memory_slave.sv
// tb_avalon_mm_data_memory_slave: two instances (WAIT_CYCLES=2 at base 0x1000,
// WAIT_CYCLES=0 at base 0) driven by directed and random transactions against a memory model.
module tb_avalon_mm_data_memory_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        rd [2];
    logic        wr [2];
    logic        wreq [2];
    logic        aerr [2];

    logic [31:0] mdl [2][1024];
    logic [31:0] rdm [2];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    avalon_mm_data_memory_slave #(
        .DEPTH(1024), .ADDR_W(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s_address(addr[0]), .s_writedata(wdata[0]),
        .s_read(rd[0]), .s_write(wr[0]), .s_readdata(rdata[0]),
        .s_waitrequest(wreq[0]), .access_error(aerr[0])
    );

    avalon_mm_data_memory_slave #(
        .DEPTH(1024), .ADDR_W(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .s_address(addr[1]), .s_writedata(wdata[1]),
        .s_read(rd[1]), .s_write(wr[1]), .s_readdata(rdata[1]),
        .s_waitrequest(wreq[1]), .access_error(aerr[1])
    );

    function automatic logic [31:0] base_of(input int k);
        return k == 0 ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic int wait_of(input int k);
        return k == 0 ? 2 : 0;
    endfunction

    function automatic bit in_win(input int k, input logic [31:0] a);
        return a >= base_of(k) && ((a - base_of(k)) >> 2) < 32'd1024;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction, started at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic op(input int k, input logic [31:0] a, input logic [31:0] d, input bit r, input bit w);
        bit          iw = in_win(k, a);
        int          wd = iw ? int'((a - base_of(k)) >> 2) : 0;
        logic [31:0] exp_rd = r ? (iw ? mdl[k][wd] : 32'h0) : rdm[k];
        bit          done = 0;
        addr[k] = a; wdata[k] = d; rd[k] = r; wr[k] = w;
        for (int i = 0; i < 40 && !done; i++) begin
            check("rdata", rdata[k], i == 0 ? rdm[k] : exp_rd);
            if (!wreq[k]) begin
                check("latency", 32'(i), 32'(wait_of(k) + 1));
                check("aerr_ack", 32'(aerr[k]), 32'(!iw));
                done = 1;
            end else begin
                check("aerr_wait", 32'(aerr[k]), 32'h0);
                @(negedge clk);
            end
        end
        if (!done)
            check("timeout", 32'h0, 32'h1);
        rd[k] = 0; wr[k] = 0;
        rdm[k] = exp_rd;
        if (w && !r && iw)
            mdl[k][wd] = d;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        int w = $urandom_range(0, 31);
        int sel = $urandom_range(0, 7);
        logic [31:0] lo = 32'($urandom_range(0, 3));
        w = w < 16 ? w : w + 992;
        if (sel == 0)
            return base_of(k) + 32'h1000 + 32'(4 * $urandom_range(0, 3)) + lo;
        if (sel == 1 && k == 0)
            return base_of(k) - 32'(4 * $urandom_range(1, 3)) + lo;
        return base_of(k) + 32'(4 * w) + lo;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            addr[k] = 0; wdata[k] = 0; rd[k] = 0; wr[k] = 0; rdm[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_wreq", 32'(wreq[k]), 32'h1);
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_aerr", 32'(aerr[k]), 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 32; w++)
                op(k, base_of(k) + 32'(4 * (w < 16 ? w : w + 992)), $urandom, 1, 0) ;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 32; w++)
                op(k, base_of(k) + 32'(4 * (w < 16 ? w : w + 992)), $urandom, 0, 1);
        for (int k = 0; k < 2; k++) begin
            op(k, base_of(k) + 8, 32'hCAFE_0001, 0, 1);
            op(k, base_of(k) + 8, 32'h0, 1, 0);
            op(k, base_of(k) + 32'h1000, 32'h0, 1, 0);
            op(k, base_of(k) + 32'h1000, 32'h1234_5678, 0, 1);
            op(k, base_of(k), 32'h0, 1, 0);
            op(k, base_of(k) + 16, 32'hDEAD_BEEF, 1, 1);
            op(k, base_of(k) + 16, 32'h0, 1, 0);
        end
        op(0, 32'h0000_0FFC, 32'h5555_AAAA, 0, 1);
        op(0, 32'h0000_1000 + 32'(4 * 1023), 32'h0, 1, 0);
        op(1, 32'h0, 32'h0, 1, 0);
        op(1, 32'h4, 32'h0, 1, 0);
        addr[0] = 32'h0000_100C; wdata[0] = 32'hBAD0_0003; wr[0] = 1;
        @(negedge clk);
        check("abort_busy", 32'(wreq[0]), 32'h1);
        wr[0] = 0;
        repeat (3) begin
            @(negedge clk);
            check("abort_idle", 32'(wreq[0]), 32'h1);
            check("abort_aerr", 32'(aerr[0]), 32'h0);
        end
        op(0, 32'h0000_100C, 32'h0, 1, 0);
        op(0, 32'h0000_1008, 32'h0, 1, 0);
        addr[0] = 32'h0000_1014; wdata[0] = 32'hBAD0_0005; wr[0] = 1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_mid_wreq", 32'(wreq[k]), 32'h1);
            check("rst_mid_rdata", rdata[k], 32'h0);
        end
        wr[0] = 0;
        @(negedge clk);
        reset_n = 1'b1;
        rdm[0] = 0; rdm[1] = 0;
        @(negedge clk);
        op(0, 32'h0000_1014, 32'h0, 1, 0);
        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(0, 1);
            int kind = $urandom_range(0, 8);
            op(k, rand_addr(k), $urandom, kind < 4 || kind == 8, kind >= 4);
            if ($urandom_range(0, 3) == 0)
                @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
